sna_issue_sequencer: RTL and testbench

Bit-serial issue sequencer and result accumulator sitting in front of the shift-and-add stage of the CIM macro datapath. Accepts one ADC sample per input bit-slice over a valid/ready handshake, computes the ones count of the applied input slice, and drives one paced transaction into the shift-and-add stage. It then waits for that stage's result and accumulates it per filter. After `BIT_IFM` slices it emits the signed accumulated partial sum.

---
 rtl/sna_issue_sequencer_if.sv | 64 ++++++
 rtl/sna_issue_sequencer.sv | 154 +++++++++++++++
 tb/tb_sna_issue_sequencer.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/sna_issue_sequencer_if.sv
// Bundle of the job, ADC and shift-and-add signals of sna_issue_sequencer.
// slave: the sequencer's view; master: the surrounding datapath or bench.
// The err_timeout member exists only when SNA_SEQ_TIMEOUT_EN is defined.
interface sna_issue_sequencer_if #(
  parameter int BIT_CELL       = 1,
  parameter int BIT_DAC        = 1,
  parameter int BIT_W          = 8,
  parameter int OUY            = 32,
  parameter int BIT_IFM        = 8,
  parameter int MAX_NUM_FILTER = 1
);
  localparam int ADC_PRECISION = BIT_CELL + BIT_DAC + $clog2(OUY)
                                 - (((BIT_CELL != 1) && (BIT_DAC != 1)) ? 0 : 1);
  localparam int BIT_ONES = $clog2(OUY);
  localparam int BIT_IBP  = $clog2(BIT_IFM);
  localparam int BIT_RES  = ADC_PRECISION + BIT_W + BIT_IFM - 1;
  localparam int BIT_ACC  = BIT_RES + BIT_IBP;

  // Handshakes: a sample moves on adc_valid && adc_ready at a rising edge.
  // sna_in_valid is a single-cycle strobe with the sna_* fields stable,
  // and sna_out_valid is a single-cycle result strobe (no back-pressure).
  logic                              job_start;
  logic [MAX_NUM_FILTER*BIT_W-1:0]   job_wbp;
  logic                              job_busy;
  logic                              adc_valid;
  logic                              adc_ready;
  logic [ADC_PRECISION-1:0]          adc_data;
  logic [OUY-1:0]                    adc_slice;
  logic                              sna_in_valid;
  logic [ADC_PRECISION-1:0]          sna_adc_result;
  logic [MAX_NUM_FILTER*BIT_W-1:0]   sna_weight_bit_position;
  logic [BIT_ONES-1:0]               sna_ones_counter;
  logic [BIT_IBP-1:0]                sna_input_bit_position;
  logic                              sna_out_valid;
  logic [MAX_NUM_FILTER*BIT_RES-1:0] sna_result;
  logic                              acc_valid;
  logic [MAX_NUM_FILTER*BIT_ACC-1:0] acc_out;
  logic                              ones_sat;
`ifdef SNA_SEQ_TIMEOUT_EN
  logic                              err_timeout;

  modport slave (
    input  job_start, job_wbp, adc_valid, adc_data, adc_slice, sna_out_valid, sna_result,
    output job_busy, adc_ready, sna_in_valid, sna_adc_result, sna_weight_bit_position,
           sna_ones_counter, sna_input_bit_position, acc_valid, acc_out, ones_sat, err_timeout
  );
  modport master (
    output job_start, job_wbp, adc_valid, adc_data, adc_slice, sna_out_valid, sna_result,
    input  job_busy, adc_ready, sna_in_valid, sna_adc_result, sna_weight_bit_position,
           sna_ones_counter, sna_input_bit_position, acc_valid, acc_out, ones_sat, err_timeout
  );
`else
  modport slave (
    input  job_start, job_wbp, adc_valid, adc_data, adc_slice, sna_out_valid, sna_result,
    output job_busy, adc_ready, sna_in_valid, sna_adc_result, sna_weight_bit_position,
           sna_ones_counter, sna_input_bit_position, acc_valid, acc_out, ones_sat
  );
  modport master (
    output job_start, job_wbp, adc_valid, adc_data, adc_slice, sna_out_valid, sna_result,
    input  job_busy, adc_ready, sna_in_valid, sna_adc_result, sna_weight_bit_position,
           sna_ones_counter, sna_input_bit_position, acc_valid, acc_out, ones_sat
  );
`endif
endinterface

// File: rtl/sna_issue_sequencer.sv
// Bit-serial issue sequencer and per-filter result accumulator in front of
// the shift-and-add stage. One ADC sample per input slice is turned into one
// paced shift-and-add transaction; results are summed over BIT_IFM slices.
// Optional watchdog on the result wait: define SNA_SEQ_TIMEOUT_EN.
module sna_issue_sequencer #(
  parameter int BIT_CELL       = 1,
  parameter int BIT_DAC        = 1,
  parameter int BIT_W          = 8,
  parameter int OUY            = 32,
  parameter int BIT_IFM        = 8,
  parameter int MAX_NUM_FILTER = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  sna_issue_sequencer_if.slave  bus,
  output logic [2:0]            state_dbg
);
  localparam int ADC_PRECISION = BIT_CELL + BIT_DAC + $clog2(OUY)
                                 - (((BIT_CELL != 1) && (BIT_DAC != 1)) ? 0 : 1);
  localparam int BIT_ONES = $clog2(OUY);
  localparam int BIT_IBP  = $clog2(BIT_IFM);
  localparam int BIT_RES  = ADC_PRECISION + BIT_W + BIT_IFM - 1;
  localparam int BIT_ACC  = BIT_RES + BIT_IBP;
  localparam int BIT_CNT  = $clog2(OUY + 1);
  localparam int ONES_MAX = (1 << BIT_ONES) - 1;

  typedef enum logic [2:0] {IDLE, WAIT_ADC, ISSUE, WAIT_RES, DONE} state_t;

  state_t                            state_q, state_d;
  logic [BIT_IBP-1:0]                bit_cnt;
  logic                              last_slice;
  logic [BIT_CNT-1:0]                pop;
  logic                              pop_over;
  logic [BIT_ONES-1:0]               pop_sat;
  logic                              timeout;

  logic                              in_valid_q;
  logic [ADC_PRECISION-1:0]          adc_res_q;
  logic [MAX_NUM_FILTER*BIT_W-1:0]   wbp_q;
  logic [BIT_ONES-1:0]               ones_q;
  logic [BIT_IBP-1:0]                ibp_q;
  logic                              acc_valid_q;
  logic [MAX_NUM_FILTER*BIT_ACC-1:0] acc_q;
  logic                              ones_sat_q;

  assign last_slice = (bit_cnt == BIT_IBP'(BIT_IFM - 1));

`ifdef SNA_SEQ_TIMEOUT_EN
  logic [9:0] wd_cnt;
  logic       err_q;
  // The 1023rd cycle in WAIT_RES without a result gives up on the job.
  assign timeout = (state_q == WAIT_RES) && !bus.sna_out_valid && (wd_cnt == 10'd1022);
  assign bus.err_timeout = err_q;

  // Watchdog: restarted on every issue, counts cycles spent waiting for a result.
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      err_q <= timeout;
      if (state_q == ISSUE) wd_cnt <= '0;
      else if (state_q == WAIT_RES) wd_cnt <= wd_cnt + 10'd1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // Ones count of the applied slice, saturated to the field width.
  always_comb begin
    pop = '0;
    for (int i = 0; i < OUY; i++) pop = pop + BIT_CNT'(bus.adc_slice[i]);
  end
  assign pop_over = int'(pop) > ONES_MAX;
  assign pop_sat  = pop_over ? BIT_ONES'(ONES_MAX) : BIT_ONES'(pop);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state decode; ISSUE always lasts one cycle so shift-and-add sees one strobe.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (bus.job_start) state_d = WAIT_ADC;
      WAIT_ADC: if (bus.adc_valid) state_d = ISSUE;
      ISSUE:    state_d = WAIT_RES;
      WAIT_RES: begin
        if (bus.sna_out_valid) state_d = last_slice ? DONE : WAIT_ADC;
        else if (timeout)      state_d = IDLE;
      end
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Datapath registers: job setup, issue fields, strobes and accumulation.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_valid_q  <= 1'b0;
      adc_res_q   <= '0;
      wbp_q       <= '0;
      ones_q      <= '0;
      ibp_q       <= '0;
      acc_valid_q <= 1'b0;
      acc_q       <= '0;
      ones_sat_q  <= 1'b0;
      bit_cnt     <= '0;
    end else begin
      in_valid_q  <= 1'b0;
      acc_valid_q <= 1'b0;
      case (state_q)
        IDLE: if (bus.job_start) begin
          wbp_q      <= bus.job_wbp;
          acc_q      <= '0;
          bit_cnt    <= '0;
          ones_sat_q <= 1'b0;
        end
        WAIT_ADC: if (bus.adc_valid) begin
          adc_res_q  <= bus.adc_data;
          ibp_q      <= bit_cnt;
          ones_q     <= pop_sat;
          in_valid_q <= 1'b1;
          if (pop_over) ones_sat_q <= 1'b1;
        end
        WAIT_RES: if (bus.sna_out_valid) begin
          for (int f = 0; f < MAX_NUM_FILTER; f++) begin
            acc_q[f*BIT_ACC +: BIT_ACC] <= acc_q[f*BIT_ACC +: BIT_ACC]
              + {{BIT_IBP{bus.sna_result[f*BIT_RES + BIT_RES - 1]}},
                 bus.sna_result[f*BIT_RES +: BIT_RES]};
          end
          if (last_slice) acc_valid_q <= 1'b1;
          else            bit_cnt     <= bit_cnt + BIT_IBP'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.job_busy                = (state_q != IDLE);
  assign bus.adc_ready               = (state_q == WAIT_ADC);
  assign bus.sna_in_valid            = in_valid_q;
  assign bus.sna_adc_result          = adc_res_q;
  assign bus.sna_weight_bit_position = wbp_q;
  assign bus.sna_ones_counter        = ones_q;
  assign bus.sna_input_bit_position  = ibp_q;
  assign bus.acc_valid               = acc_valid_q;
  assign bus.acc_out                 = acc_q;
  assign bus.ones_sat                = ones_sat_q;
  assign state_dbg                   = state_q;
endmodule

// File: tb/tb_sna_issue_sequencer.sv
// Bench for sna_issue_sequencer at default parameters. The reference model
// sums signed slice results with integer arithmetic and derives the issue
// fields and the completion cycle from the slice/latency schedule.
module tb_sna_issue_sequencer;
  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] state_dbg;
  int         tests = 0;
  int         fails = 0;
  int         cyc = 0;

  logic [20:0] res_q[$];
  logic [23:0] exp_q[$];

  sna_issue_sequencer_if bus ();

  sna_issue_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // Clock and cycle counter.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fill_res(input bit rnd, input logic [20:0] v);
    res_q.delete();
    for (int i = 0; i < 8; i++) res_q.push_back(rnd ? 21'($urandom) : v);
  endtask

  task automatic quiet_inputs();
    bus.job_start = 0; bus.job_wbp = '0; bus.adc_valid = 0; bus.adc_data = '0;
    bus.adc_slice = '0; bus.sna_out_valid = 0; bus.sna_result = '0;
  endtask

  // One complete job. lat<=0: random latency per slice; stall<0: random stall.
  task automatic run_job(input logic [7:0] wbp, input int lat, input int stall,
                         input bit fix_slice, input logic [31:0] slice_val, input int adc_fix,
                         input bit collide, input bit stray);
    int sum, span, c0, l, s, ones;
    bit sat;
    logic [20:0] r;
    logic [31:0] sl;
    logic [5:0]  d;
    logic [23:0] exp_acc;
    sum = 0; span = 0; sat = 0;
    @(negedge clk); bus.job_start = 1; bus.job_wbp = wbp;
    @(negedge clk); bus.job_start = 0; bus.job_wbp = 8'($urandom); c0 = cyc;
    check("busy_start", bus.job_busy, 1);
    check("ones_sat_clr", bus.ones_sat, 0);
    check("acc_clr", bus.acc_out, 0);
    for (int k = 0; k < 8; k++) begin
      s = (stall < 0) ? int'($urandom_range(0, 3)) : stall;
      l = (lat <= 0) ? int'($urandom_range(1, 6)) : lat;
      check("ready", bus.adc_ready, 1);
      for (int j = 0; j < s; j++) begin
        check("no_issue_stall", bus.sna_in_valid, 0);
        if (stray) begin bus.sna_out_valid = 1; bus.sna_result = 21'($urandom); end
        @(negedge clk);
        bus.sna_out_valid = 0;
        check("ready_stall", bus.adc_ready, 1);
      end
      exp_acc = 24'(sum);
      check("acc_partial", bus.acc_out, exp_acc);
      sl = fix_slice ? slice_val : $urandom;
      d  = (adc_fix < 0) ? 6'($urandom) : 6'(adc_fix);
      bus.adc_valid = 1; bus.adc_data = d; bus.adc_slice = sl;
      @(negedge clk);
      bus.adc_valid = 0; bus.adc_data = 6'($urandom); bus.adc_slice = $urandom;
      ones = $countones(sl);
      if (ones > 31) begin ones = 31; sat = 1; end
      check("in_valid", bus.sna_in_valid, 1);
      check("ready_issue", bus.adc_ready, 0);
      check("ones", bus.sna_ones_counter, ones);
      check("ibp", bus.sna_input_bit_position, k);
      check("adc_res", bus.sna_adc_result, d);
      check("wbp", bus.sna_weight_bit_position, wbp);
      if (collide) begin bus.job_start = 1; bus.job_wbp = ~wbp; end
      @(negedge clk);
      bus.job_start = 0;
      check("in_valid_pulse", bus.sna_in_valid, 0);
      check("busy_wait", bus.job_busy, 1);
      repeat (l - 1) @(negedge clk);
      r = (res_q.size() > 0) ? res_q.pop_front() : 21'($urandom);
      sum += int'($signed(r));
      bus.sna_out_valid = 1; bus.sna_result = r;
      @(negedge clk);
      bus.sna_out_valid = 0; bus.sna_result = 21'($urandom);
      span += s + 2 + l;
    end
    exp_q.push_back(24'(sum));
    exp_acc = exp_q.pop_front();
    check("acc_valid", bus.acc_valid, 1);
    check("acc_out", bus.acc_out, exp_acc);
    check("done_cycle", cyc - c0, span);
    check("ones_sat_done", bus.ones_sat, sat);
    @(negedge clk);
    check("acc_valid_pulse", bus.acc_valid, 0);
    check("busy_idle", bus.job_busy, 0);
    check("acc_hold", bus.acc_out, exp_acc);
    check("ones_sat_hold", bus.ones_sat, sat);
  endtask

  initial begin
    // Reset with random inputs.
    rst = 1;
    for (int i = 0; i < 2; i++) begin
      bus.job_start = 1'($urandom); bus.job_wbp = 8'($urandom);
      bus.adc_valid = 1'($urandom); bus.adc_data = 6'($urandom); bus.adc_slice = $urandom;
      bus.sna_out_valid = 1'($urandom); bus.sna_result = 21'($urandom);
      @(negedge clk);
    end
    check("rst_busy", bus.job_busy, 0);
    check("rst_ready", bus.adc_ready, 0);
    check("rst_in_valid", bus.sna_in_valid, 0);
    check("rst_adc_res", bus.sna_adc_result, 0);
    check("rst_wbp", bus.sna_weight_bit_position, 0);
    check("rst_ones", bus.sna_ones_counter, 0);
    check("rst_ibp", bus.sna_input_bit_position, 0);
    check("rst_acc_valid", bus.acc_valid, 0);
    check("rst_acc", bus.acc_out, 0);
    check("rst_ones_sat", bus.ones_sat, 0);
    quiet_inputs();
    rst = 0;
    @(negedge clk);
    check("idle_after_rst", bus.job_busy, 0);

    // Nominal job: fixed 4-cycle latency, 100 per slice -> 800 at cycle 49.
    fill_res(0, 21'd100);
    run_job(8'h35, 4, 0, 1, 32'h0000_FFFF, 5, 0, 0);

    // Negative results: -3 per slice -> -24.
    fill_res(0, 21'h1F_FFFD);
    run_job(8'hA2, 4, 0, 0, '0, -1, 0, 0);

    // Saturating popcount, then a job that must clear the sticky flag.
    fill_res(1, '0);
    run_job(8'h0F, 0, -1, 1, 32'hFFFF_FFFF, -1, 0, 0);

    // Long ADC stall, mid-job job_start and stray results in WAIT_ADC.
    fill_res(1, '0);
    run_job(8'h5C, 0, 10, 0, '0, -1, 1, 1);

    // Fully random jobs.
    for (int j = 0; j < 3; j++) begin
      fill_res(1, '0);
      run_job(8'($urandom), 0, -1, 0, '0, -1, 1'($urandom), 1'($urandom));
    end

    // Reset in WAIT_RES discards the job and the late result.
    @(negedge clk); bus.job_start = 1; bus.job_wbp = 8'h77;
    @(negedge clk); bus.job_start = 0;
    bus.adc_valid = 1; bus.adc_data = 6'd9; bus.adc_slice = 32'h0000_00FF;
    @(negedge clk); bus.adc_valid = 0;
    @(negedge clk);
    check("abort_busy_pre", bus.job_busy, 1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    check("abort_busy", bus.job_busy, 0);
    check("abort_wbp", bus.sna_weight_bit_position, 0);
    check("abort_ones", bus.sna_ones_counter, 0);
    bus.sna_out_valid = 1; bus.sna_result = 21'd100;
    @(negedge clk);
    bus.sna_out_valid = 0;
    check("abort_acc", bus.acc_out, 0);
    check("abort_acc_valid", bus.acc_valid, 0);
    check("abort_idle", bus.job_busy, 0);

`ifdef SNA_SEQ_TIMEOUT_EN
    // Watchdog: no result ever arrives.
    begin
      int n;
      @(negedge clk); bus.job_start = 1; bus.job_wbp = 8'h11;
      @(negedge clk); bus.job_start = 0;
      bus.adc_valid = 1; bus.adc_data = 6'd3; bus.adc_slice = 32'h1;
      @(negedge clk); bus.adc_valid = 0;
      @(negedge clk);
      n = 0;
      while (bus.err_timeout !== 1'b1 && n < 1100) begin
        @(negedge clk);
        n++;
      end
      check("timeout_cycle", n, 1023);
      check("timeout_idle", bus.job_busy, 0);
      check("timeout_acc_valid", bus.acc_valid, 0);
      check("timeout_acc", bus.acc_out, 0);
      @(negedge clk);
      check("timeout_pulse", bus.err_timeout, 0);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
